upsampler: RTL and testbench
============================

UPSAMPLER -- requirements
Module: upsampler

Interface
REQ-001 SHALL have parameter DATA_WIDTH_INP, default 8: input and output sample width in bits.
REQ-002 SHALL have parameter CIC_R, default 4: interpolation ratio; legal values are integers >= 1.
REQ-003 SHALL have parameter ZERO_STUFF, default 1: 1 = zero-stuff the non-sample phases; 0 = hold the last sample on them.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port inp_samp_data, input, DATA_WIDTH_INP bits, signed: input sample.
REQ-007 SHALL have port inp_samp_str, input, 1 bit: input sample write strobe.
REQ-008 SHALL have port inp_samp_rdy, output, 1 bit: the input buffer can accept a sample this cycle.
REQ-009 SHALL have port out_samp_req, input, 1 bit: downstream output-slot request, one pulse per high-rate slot.
REQ-010 SHALL have port out_samp_data, output, DATA_WIDTH_INP bits, signed: output sample, registered.
REQ-011 SHALL have port out_samp_str, output, 1 bit: out_samp_data valid, registered.
REQ-012 SHALL have port underflow, output, 1 bit: sticky flag, set when a phase-0 request finds the buffer empty.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a strobed input sample is dropped.

Function
REQ-014 SHALL hold a 2-entry FIFO for input samples, with occupancy count 0..2.
REQ-015 SHALL drive inp_samp_rdy = (count < 2), combinational from the registered count only.
REQ-016 SHALL, when inp_samp_str=1 and inp_samp_rdy=1, push inp_samp_data; the sample is visible to pops from the next cycle.
REQ-017 SHALL, when inp_samp_str=1 and inp_samp_rdy=0, drop the sample and set overflow; this holds even if a pop occurs in the same cycle.
REQ-018 SHALL keep a phase counter 0..CIC_R-1 of width max(1, clog2(CIC_R)); for CIC_R=1 the phase is always 0.
REQ-019 SHALL, on out_samp_req at phase 0 with count>0: pop the oldest sample, register it on out_samp_data, set out_samp_str=1 the next cycle, and advance the phase.
REQ-020 SHALL, on out_samp_req at phase 0 with count=0: not advance the phase, keep out_samp_str=0 and out_samp_data unchanged, and set underflow.
REQ-021 SHALL, on out_samp_req at phase p != 0: output 0 if ZERO_STUFF=1, else repeat the last popped sample; set out_samp_str=1 the next cycle and advance the phase.
REQ-022 SHALL advance the phase from CIC_R-1 back to 0.
REQ-023 SHALL have a latency of exactly 1 cycle from out_samp_req to out_samp_str, and SHALL drive out_samp_str=0 in any cycle following a cycle without out_samp_req.
REQ-024 SHALL, on a simultaneous push and pop, update count by 0; a push into an empty FIFO is not bypassed to a same-cycle pop (that case is an underflow).
REQ-025 SHALL keep the phase, FIFO and outputs unchanged when neither out_samp_req nor inp_samp_str is asserted, except out_samp_str, which returns to 0.
REQ-026 SHALL wrap the FIFO read and write pointers modulo 2.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set count=0, pointers=0, phase=0, out_samp_data=0, out_samp_str=0, underflow=0 and overflow=0.
REQ-028 SHALL let reset override all concurrent strobes and requests; a reset mid-cycle-group discards buffered samples and restarts at phase 0.
REQ-029 SHALL clear underflow and overflow only by reset.

Verification
REQ-030 SHALL cover basic interpolation: CIC_R=4, ZERO_STUFF=1, push 5 then 7, then 8 consecutive reqs -> outputs 5,0,0,0,7,0,0,0, each with out_samp_str one cycle after its req.
REQ-031 SHALL cover hold mode: ZERO_STUFF=0, CIC_R=3, push -2, then 3 reqs -> outputs -2,-2,-2.
REQ-032 SHALL cover underflow: empty FIFO, req at phase 0 -> out_samp_str=0, underflow=1, phase stays 0; a later push of 9 then req -> output 9.
REQ-033 SHALL cover overflow: push 1, 2, then 3 with no reqs -> inp_samp_rdy=0 after the second push, 3 dropped, overflow=1; the next reqs output 1, then 2 at the following phase 0.
REQ-034 SHALL cover a simultaneous full push and pop: count=2, push and phase-0 req in the same cycle -> push rejected, overflow=1, count=1.
REQ-035 SHALL cover reset mid-operation: reset at phase 2 with count=1 -> the next cycle shows all outputs 0, inp_samp_rdy=1 and phase 0; CIC_R=1 -> every req pops one sample.

Source files
------------

// File: rtl/upsampler.sv
// Zero-stuffing / sample-hold interpolator fed by a 2-deep input FIFO, driven by downstream slot requests.
// Output is registered one cycle after out_samp_req; a phase-0 request that finds the FIFO empty stalls the phase.
module upsampler #(
  parameter int DATA_WIDTH_INP = 8,
  parameter int CIC_R          = 4,
  parameter int ZERO_STUFF     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                             inp_samp_str,
  output logic                             inp_samp_rdy,
  input  logic                             out_samp_req,
  output logic signed [DATA_WIDTH_INP-1:0] out_samp_data,
  output logic                             out_samp_str,
  output logic                             underflow,
  output logic                             overflow
);

  localparam int PH_W = (CIC_R > 1) ? $clog2(CIC_R) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CIC_R - 1);

  logic signed [DATA_WIDTH_INP-1:0] r_mem [2];
  logic                             r_wr_ptr;
  logic                             r_rd_ptr;
  logic [1:0]                       r_count;
  logic [PH_W-1:0]                  r_phase;
  logic signed [DATA_WIDTH_INP-1:0] r_last;

  logic            w_phase0;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_starve;
  logic            w_adv;
  logic [PH_W-1:0] w_phase_nxt;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign inp_samp_rdy = (r_count < 2'd2);

  assign w_phase0    = (r_phase == '0);
  assign w_push      = inp_samp_str & inp_samp_rdy;
  assign w_drop      = inp_samp_str & ~inp_samp_rdy;
  assign w_pop       = out_samp_req & w_phase0 & (r_count != 2'd0);
  assign w_starve    = out_samp_req & w_phase0 & (r_count == 2'd0);
  assign w_adv       = out_samp_req & ~w_starve;
  assign w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= inp_samp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
    end else if (w_adv) begin
      r_phase <= w_phase_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
      r_last        <= '0;
    end else begin
      out_samp_str <= w_adv;
      if (w_pop) begin
        out_samp_data <= r_mem[r_rd_ptr];
        r_last        <= r_mem[r_rd_ptr];
      end else if (out_samp_req && !w_phase0) begin
        out_samp_data <= (ZERO_STUFF != 0) ? '0 : r_last;
      end
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (w_starve) begin
        underflow <= 1'b1;
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_upsampler.sv
// Directed bench for upsampler: three instances (R=4 zero-stuff, R=3 hold, R=1) checked against a queue model.
module tb_upsampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_v [3];
  logic              str_v [3];
  logic signed [7:0] din_v [3];
  logic              req_v [3];
  logic              rdy_o [3];
  logic signed [7:0] dat_o [3];
  logic              ost_o [3];
  logic              uf_o  [3];
  logic              ovf_o [3];

  upsampler #(.DATA_WIDTH_INP(8), .CIC_R(4), .ZERO_STUFF(1)) u_zs (
    .clk(clk), .reset(rst_v[0]), .inp_samp_data(din_v[0]), .inp_samp_str(str_v[0]),
    .inp_samp_rdy(rdy_o[0]), .out_samp_req(req_v[0]), .out_samp_data(dat_o[0]),
    .out_samp_str(ost_o[0]), .underflow(uf_o[0]), .overflow(ovf_o[0]));

  upsampler #(.DATA_WIDTH_INP(8), .CIC_R(3), .ZERO_STUFF(0)) u_hold (
    .clk(clk), .reset(rst_v[1]), .inp_samp_data(din_v[1]), .inp_samp_str(str_v[1]),
    .inp_samp_rdy(rdy_o[1]), .out_samp_req(req_v[1]), .out_samp_data(dat_o[1]),
    .out_samp_str(ost_o[1]), .underflow(uf_o[1]), .overflow(ovf_o[1]));

  upsampler #(.DATA_WIDTH_INP(8), .CIC_R(1), .ZERO_STUFF(1)) u_r1 (
    .clk(clk), .reset(rst_v[2]), .inp_samp_data(din_v[2]), .inp_samp_str(str_v[2]),
    .inp_samp_rdy(rdy_o[2]), .out_samp_req(req_v[2]), .out_samp_data(dat_o[2]),
    .out_samp_str(ost_o[2]), .underflow(uf_o[2]), .overflow(ovf_o[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the instance under test
  int                sel = 0;
  int                m_r = 4;
  bit                m_zs = 1'b1;
  logic signed [7:0] m_fifo [$];
  logic signed [7:0] exp_q [$];
  int                m_phase = 0;
  logic signed [7:0] m_last = 0;
  logic signed [7:0] m_dout = 0;
  logic              m_str = 0;
  logic              m_uf = 0;
  logic              m_ovf = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (inst %0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  task automatic pick(input int i, input int r, input bit zs);
    sel  = i;
    m_r  = r;
    m_zs = zs;
  endtask

  task automatic step(input logic r, input logic s, input logic signed [7:0] d, input logic q);
    int                pre;
    logic signed [7:0] v;
    logic signed [7:0] got;
    rst_v[sel] = r;
    str_v[sel] = s;
    din_v[sel] = d;
    req_v[sel] = q;
    pre = m_fifo.size();
    if (r) begin
      m_fifo.delete();
      exp_q.delete();
      m_phase = 0;
      m_last  = 0;
      m_dout  = 0;
      m_str   = 0;
      m_uf    = 0;
      m_ovf   = 0;
    end else begin
      m_str = 0;
      if (q) begin
        if (m_phase == 0) begin
          if (pre > 0) begin
            v = m_fifo.pop_front();
            m_last = v;
            m_dout = v;
            m_str  = 1;
            exp_q.push_back(v);
            m_phase = (m_phase == m_r - 1) ? 0 : m_phase + 1;
          end else begin
            m_uf = 1;
          end
        end else begin
          v = m_zs ? 8'sd0 : m_last;
          m_dout = v;
          m_str  = 1;
          exp_q.push_back(v);
          m_phase = (m_phase == m_r - 1) ? 0 : m_phase + 1;
        end
      end
      if (s) begin
        if (pre < 2) m_fifo.push_back(d);
        else         m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    rst_v[sel] = 1'b0;
    str_v[sel] = 1'b0;
    din_v[sel] = 8'sd0;
    req_v[sel] = 1'b0;
    chk("out_samp_str", ost_o[sel], m_str);
    if (ost_o[sel] === 1'b1) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL scoreboard: observed unexpected strobe expected none (inst %0d)", sel);
      end
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("out_samp_data", dat_o[sel], got);
      end
    end else begin
      chk("out_data_hold", dat_o[sel], m_dout);
    end
    chk("inp_samp_rdy", rdy_o[sel], (m_fifo.size() < 2) ? 1'b1 : 1'b0);
    chk("underflow", uf_o[sel], m_uf);
    chk("overflow", ovf_o[sel], m_ovf);
  endtask

  task automatic reqs(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'sd0, 1'b1);
  endtask

  task automatic push(input logic signed [7:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1;
      str_v[i] = 1'b0;
      din_v[i] = 8'sd0;
      req_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

    // R=4, zero-stuffing
    pick(0, 4, 1'b1);
    step(1'b1, 1'b0, 8'sd0, 1'b0);
    push(8'sd5);
    push(8'sd7);
    reqs(8);
    step(1'b0, 1'b0, 8'sd0, 1'b0);
    reqs(1);
    push(8'sd9);
    reqs(4);
    push(8'sd1);
    push(8'sd2);
    push(8'sd3);
    reqs(8);
    push(8'sd4);
    push(8'sd6);
    step(1'b0, 1'b1, 8'sd8, 1'b1);
    reqs(3);
    reqs(4);
    step(1'b0, 1'b0, 8'sd0, 1'b0);
    step(1'b0, 1'b1, 8'sd10, 1'b1);
    reqs(4);
    push(8'sd11);
    push(8'sd12);
    reqs(2);
    step(1'b1, 1'b0, 8'sd0, 1'b1);
    push(8'sd13);
    reqs(1);

    // R=3, hold last sample
    pick(1, 3, 1'b0);
    step(1'b1, 1'b0, 8'sd0, 1'b0);
    push(-8'sd2);
    reqs(3);
    push(8'sd4);
    step(1'b0, 1'b0, 8'sd0, 1'b0);
    reqs(3);

    // R=1, every request pops
    pick(2, 1, 1'b1);
    step(1'b1, 1'b0, 8'sd0, 1'b0);
    push(8'sd1);
    push(8'sd2);
    reqs(2);
    reqs(1);
    step(1'b0, 1'b1, -8'sd7, 1'b1);
    reqs(1);

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
